// File: rtl/vedic_pkg.sv
// -----------------------------------------------------------------------------
// vedic_pkg
// Shared definitions for the sequential Vedic 4x4 multiplier:
//   - state_t : FSM state encoding (IDLE=0, CALC=1, DONE=2)
//   - STEPS   : number of 2x2 partial products folded per multiplication
//   - pp_place: places a 4-bit 2x2 partial product at its weight in an
//               8-bit sum, given the operand half indices i (of a) and j (of b)
// -----------------------------------------------------------------------------
package vedic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int STEPS = 4;

  // Partial product of a-half i and b-half j has weight 4^(i+j).
  function automatic logic [7:0] pp_place(input logic [3:0] pp,
                                          input logic       i,
                                          input logic       j);
    logic [1:0] half_sum;
    half_sum = {1'b0, i} + {1'b0, j};
    return {4'b0000, pp} << {half_sum, 1'b0};
  endfunction

endpackage

// File: rtl/vedic_multiplier_2x2.sv
// -----------------------------------------------------------------------------
// vedic_multiplier_2x2
// Combinational 2x2 unsigned multiplier built the Vedic (Urdhva-Tiryagbhyam)
// way: vertical and crosswise bit products combined with two half adders.
// Ports:
//   a [1:0] : multiplicand
//   b [1:0] : multiplier
//   p [3:0] : product a*b
// -----------------------------------------------------------------------------
module vedic_multiplier_2x2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);

  logic cross_carry_s;
  logic msb_prod_s;

  assign msb_prod_s    = a[1] & b[1];
  assign cross_carry_s = (a[1] & b[0]) & (a[0] & b[1]);

  assign p[0] = a[0] & b[0];
  assign p[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
  assign p[2] = msb_prod_s ^ cross_carry_s;
  assign p[3] = msb_prod_s & cross_carry_s;

endmodule

// File: rtl/vedic_seq_mult_4x4.sv
// -----------------------------------------------------------------------------
// vedic_seq_mult_4x4
// Sequential 4x4 unsigned multiplier. One operand pair is accepted in IDLE,
// four 2x2 partial products are folded into an 8-bit sum over four CALC
// cycles using a single vedic_multiplier_2x2, and the result is presented in
// DONE until the downstream consumer takes it.
//
// Parameters:
//   ACC_W     : width of the optional running-sum accumulator
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   in_valid  : operand pair present
//   in_ready  : block can accept operands (IDLE only)
//   a, b      : 4-bit unsigned operands
//   out_valid : product valid (DONE only)
//   out_ready : downstream accepts product
//   product   : 8-bit unsigned a*b, held until the next DONE
//   busy      : high in CALC or DONE
//   acc_clr   : accumulator clear            (VEDIC_SEQ_ACC_EN only)
//   acc_out   : running sum of products      (VEDIC_SEQ_ACC_EN only)
//
// Build option: define VEDIC_SEQ_ACC_EN to compile in the accumulator.
// -----------------------------------------------------------------------------
module vedic_seq_mult_4x4
  import vedic_pkg::*;
#(
  parameter int ACC_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       a,
  input  logic [3:0]       b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       product,
  output logic             busy
`ifdef VEDIC_SEQ_ACC_EN
  ,
  input  logic             acc_clr,
  output logic [ACC_W-1:0] acc_out
`endif
);

  state_t     state_r;
  state_t     state_s;
  logic [1:0] step_r;
  logic [3:0] a_r;
  logic [3:0] b_r;
  logic [7:0] psum_r;
  logic [7:0] product_r;
  logic       out_valid_r;
  logic       in_ready_r;
  logic       busy_r;

  logic       in_hs_s;
  logic       out_hs_s;
  logic       last_step_s;
  logic [1:0] a_half_s;
  logic [1:0] b_half_s;
  logic [3:0] pp_s;
  logic [7:0] psum_next_s;

  assign in_hs_s     = in_valid & in_ready_r;
  assign out_hs_s    = out_valid_r & out_ready;
  assign last_step_s = (step_r == 2'(STEPS - 1));

  // Operand-half selection: step[0] picks the half of a, step[1] the half of b.
  always_comb begin
    a_half_s = a_r[1:0];
    b_half_s = b_r[1:0];
    if (step_r[0]) begin
      a_half_s = a_r[3:2];
    end else begin
      a_half_s = a_r[1:0];
    end
    if (step_r[1]) begin
      b_half_s = b_r[3:2];
    end else begin
      b_half_s = b_r[1:0];
    end
  end

  vedic_multiplier_2x2 u_mult (
    .a (a_half_s),
    .b (b_half_s),
    .p (pp_s)
  );

  assign psum_next_s = psum_r + pp_place(pp_s, step_r[0], step_r[1]);

  // Next-state logic for the IDLE -> CALC -> DONE sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_hs_s) begin
          state_s = CALC;
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        if (last_step_s) begin
          state_s = DONE;
        end else begin
          state_s = CALC;
        end
      end
      DONE: begin
        if (out_hs_s) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register plus status flags registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == IDLE);
      busy_r      <= (state_s != IDLE);
      out_valid_r <= (state_s == DONE);
    end
  end

  // Datapath: capture operands, fold partial products, latch the result.
  // Operands are only sampled on the input handshake, so later changes on
  // a/b cannot disturb a calculation in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_r    <= 2'd0;
      a_r       <= 4'd0;
      b_r       <= 4'd0;
      psum_r    <= 8'd0;
      product_r <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_hs_s) begin
            a_r    <= a;
            b_r    <= b;
            psum_r <= 8'd0;
            step_r <= 2'd0;
          end
        end
        CALC: begin
          psum_r <= psum_next_s;
          step_r <= step_r + 2'd1;
          if (last_step_s) begin
            product_r <= psum_next_s;
          end
        end
        default: begin
          step_r <= step_r;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign busy      = busy_r;
  assign out_valid = out_valid_r;
  assign product   = product_r;

`ifdef VEDIC_SEQ_ACC_EN
  logic [ACC_W-1:0] acc_r;

  // Running sum of delivered products; a clear coinciding with a delivery
  // restarts the sum from that product.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r <= '0;
    end else if (out_hs_s) begin
      if (acc_clr) begin
        acc_r <= ACC_W'(product_r);
      end else begin
        acc_r <= acc_r + ACC_W'(product_r);
      end
    end else if (acc_clr) begin
      acc_r <= '0;
    end
  end

  assign acc_out = acc_r;
`endif

endmodule

// File: tb/tb_vedic_seq_mult_4x4.sv
// -----------------------------------------------------------------------------
// tb_vedic_seq_mult_4x4
// Directed self-checking bench for vedic_seq_mult_4x4.
// -----------------------------------------------------------------------------
module tb_vedic_seq_mult_4x4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] product;
  logic       busy;
  logic       acc_clr;
  logic [7:0] acc_out;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  vedic_seq_mult_4x4 #(.ACC_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
`ifdef VEDIC_SEQ_ACC_EN
    ,
    .acc_clr   (acc_clr),
    .acc_out   (acc_out)
`endif
  );

`ifndef VEDIC_SEQ_ACC_EN
  assign acc_out = 8'd0;
`endif

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One full transaction with out_ready high; returns the presented product
  // and the number of cycles from the handshake edge to out_valid.
  task automatic do_op(input logic [3:0] aa, input logic [3:0] bb, input logic clr,
                       output logic [7:0] prod, output int lat);
    a        = aa;
    b        = bb;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat      = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    prod    = product;
    acc_clr = clr;
    tick();
    acc_clr = 1'b0;
  endtask

  initial begin
    logic [7:0] p;
    int         lat;
    logic [7:0] idx;

    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = 4'd0;
    b         = 4'd0;
    out_ready = 1'b0;
    acc_clr   = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_product", product, 0);

    // 15*15 with exact latency
    out_ready = 1'b1;
    a = 4'd15; b = 4'd15; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("ff_t1_in_ready", in_ready, 0);
    chk("ff_t1_busy", busy, 1);
    chk("ff_t1_out_valid", out_valid, 0);
    tick(); tick(); tick();
    chk("ff_t4_out_valid", out_valid, 0);
    tick();
    chk("ff_t5_out_valid", out_valid, 1);
    chk("ff_t5_product", product, 225);
    chk("ff_t5_busy", busy, 1);
    tick();
    chk("ff_t6_in_ready", in_ready, 1);
    chk("ff_t6_out_valid", out_valid, 0);
    chk("ff_t6_busy", busy, 0);
    chk("ff_t6_product_held", product, 225);

    // 9*6 with backpressure for 10 cycles
    out_ready = 1'b0;
    a = 4'd9; b = 4'd6; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick(); tick();
    for (int k = 0; k < 10; k++) begin
      chk("bp_out_valid", out_valid, 1);
      chk("bp_product", product, 54);
      chk("bp_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_release_out_valid", out_valid, 0);
    chk("bp_release_product", product, 54);

    // Reset in the middle of 7*5
    a = 4'd7; b = 4'd5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_product", product, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_busy", busy, 0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("midrst_no_result", out_valid, 0);
    end

    // 3*12 with operands scrambled during CALC
    a = 4'd3; b = 4'd12; in_valid = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      a        = 4'($urandom_range(15, 0));
      b        = 4'($urandom_range(15, 0));
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("scramble_out_valid", out_valid, 1);
    chk("scramble_product", product, 36);
    tick();
    chk("scramble_in_ready", in_ready, 1);

`ifdef VEDIC_SEQ_ACC_EN
    // Accumulator: wrap at 8 bits, then clear coinciding with a delivery
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    chk("acc_clear", acc_out, 0);
    do_op(4'd15, 4'd14, 1'b0, p, lat);
    chk("acc_p1", p, 210);
    chk("acc_sum1", acc_out, 210);
    do_op(4'd10, 4'd10, 1'b0, p, lat);
    chk("acc_p2", p, 100);
    chk("acc_wrap", acc_out, 54);
    do_op(4'd3, 4'd5, 1'b1, p, lat);
    chk("acc_p3", p, 15);
    chk("acc_clr_with_hs", acc_out, 15);
`endif

    // Exhaustive, back-to-back
    for (int i = 0; i < 256; i++) begin
      idx = i[7:0];
      chk("exh_in_ready", in_ready, 1);
      do_op(idx[7:4], idx[3:0], 1'b0, p, lat);
      chk("exh_product", p, 32'(idx[7:4]) * 32'(idx[3:0]));
      chk("exh_latency", lat, 4);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
